// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the pwm voice scheduler
package synth_pkg;
  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 16;
  localparam int CH_IDX_W = 3;
  localparam int NOTE_W   = 8;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} ch_state_t;
endpackage

// File: rtl/pwm_env_channel.sv
// rtl/pwm_env_channel.sv - one voice: note/target storage and linear attack/release envelope
module pwm_env_channel
  import synth_pkg::*;
#(
  parameter logic [DATA_W-1:0] STEP = 16'h0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              on_load,
  input  logic              alloc,
  input  logic              off_load,
  input  logic [NOTE_W-1:0] cmd_note,
  input  logic [DATA_W-1:0] cmd_level,
  output ch_state_t         state,
  output logic [DATA_W-1:0] level,
  output logic [NOTE_W-1:0] note
);
  ch_state_t         state_n;
  logic [DATA_W-1:0] level_n;
  logic [NOTE_W-1:0] note_n;
  logic [DATA_W-1:0] target, target_n;
  logic [DATA_W:0]   up_sum;

  assign up_sum = {1'b0, level} + {1'b0, STEP};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      level  <= '0;
      note   <= '0;
      target <= '0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      note   <= note_n;
      target <= target_n;
    end
  end

  // A command load on this channel takes priority and swallows a coincident tick.
  always_comb begin
    state_n  = state;
    level_n  = level;
    note_n   = note;
    target_n = target;
    if (on_load) begin
      state_n  = ATTACK;
      target_n = cmd_level;
      if (alloc) begin
        note_n  = cmd_note;
        level_n = '0;
      end
    end else if (off_load) begin
      state_n = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (up_sum >= {1'b0, target}) begin
            level_n = target;
            state_n = SUSTAIN;
          end else begin
            level_n = up_sum[DATA_W-1:0];
          end
        end
        RELEASE: begin
          if ({1'b0, level} <= {1'b0, STEP}) begin
            level_n = '0;
            state_n = IDLE;
          end else begin
            level_n = level - STEP;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pwm_voice_scheduler.sv
// rtl/pwm_voice_scheduler.sv - note-on/off voice allocator driving eight pwm duty words
module pwm_voice_scheduler
  import synth_pkg::*;
#(
  parameter int                TICK_DIV = 1000,
  parameter logic [DATA_W-1:0] STEP     = 16'h0100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_on,
  input  logic [NOTE_W-1:0]        cmd_note,
  input  logic [DATA_W-1:0]        cmd_level,
  output logic                     resp_valid,
  output logic [CH_IDX_W-1:0]      resp_ch,
  output logic                     resp_err,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH*DATA_W-1:0] pwm_regs
);
  ch_state_t           st    [NUM_CH];
  logic [DATA_W-1:0]   lvl   [NUM_CH];
  logic [NOTE_W-1:0]   notes [NUM_CH];
  logic [15:0]         tick_cnt;
  logic                tick;
  logic                accept;
  logic                on_hit, free_hit, off_hit;
  logic [CH_IDX_W-1:0] on_idx, free_idx, off_idx;
  logic                sel_ok, sel_alloc;
  logic [CH_IDX_W-1:0] sel_idx;

  assign tick   = (tick_cnt == 16'(TICK_DIV - 1));
  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  end

  // Descending scan so the last assignment leaves the lowest matching index.
  always_comb begin
    on_hit   = 1'b0;
    on_idx   = '0;
    free_hit = 1'b0;
    free_idx = '0;
    off_hit  = 1'b0;
    off_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (st[i] != IDLE && notes[i] == cmd_note) begin
        on_hit = 1'b1;
        on_idx = CH_IDX_W'(i);
      end
      if (st[i] == IDLE) begin
        free_hit = 1'b1;
        free_idx = CH_IDX_W'(i);
      end
      if ((st[i] == ATTACK || st[i] == SUSTAIN) && notes[i] == cmd_note) begin
        off_hit = 1'b1;
        off_idx = CH_IDX_W'(i);
      end
    end
    if (cmd_on) begin
      sel_ok    = on_hit | free_hit;
      sel_idx   = on_hit ? on_idx : free_idx;
      sel_alloc = ~on_hit;
    end else begin
      sel_ok    = off_hit;
      sel_idx   = off_idx;
      sel_alloc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_ch    <= '0;
      resp_err   <= RESP_OK;
    end else begin
      cmd_ready  <= ~accept;
      resp_valid <= accept;
      if (accept) begin
        resp_err <= sel_ok ? RESP_OK : RESP_ERR;
        resp_ch  <= sel_ok ? sel_idx : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = accept & sel_ok & (sel_idx == CH_IDX_W'(g));

    pwm_env_channel #(.STEP(STEP)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .on_load  (hit & cmd_on),
      .alloc    (sel_alloc),
      .off_load (hit & ~cmd_on),
      .cmd_note (cmd_note),
      .cmd_level(cmd_level),
      .state    (st[g]),
      .level    (lvl[g]),
      .note     (notes[g])
    );

    assign ch_busy[g]                   = (st[g] != IDLE);
    assign pwm_regs[DATA_W*g +: DATA_W] = lvl[g];
  end
endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// tb/tb_pwm_voice_scheduler.sv - directed self-checking bench for pwm_voice_scheduler
module tb_pwm_voice_scheduler;
  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_on;
  logic [7:0]   cmd_note;
  logic [15:0]  cmd_level;
  logic         resp_valid;
  logic [2:0]   resp_ch;
  logic         resp_err;
  logic [7:0]   ch_busy;
  logic [127:0] pwm_regs;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_cnt;

  pwm_voice_scheduler #(.TICK_DIV(4), .STEP(16'h4000)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_on    (cmd_on),
    .cmd_note  (cmd_note),
    .cmd_level (cmd_level),
    .resp_valid(resp_valid),
    .resp_ch   (resp_ch),
    .resp_err  (resp_err),
    .ch_busy   (ch_busy),
    .pwm_regs  (pwm_regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference tick counter: the posedge after a negedge with tb_cnt == 3 is a tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tb_cnt <= 0;
    else if (tb_cnt == 3) tb_cnt <= 0;
    else                 tb_cnt <= tb_cnt + 1;
  end

  function automatic logic [15:0] lvl(input int i);
    return pwm_regs[16*i +: 16];
  endfunction

  // Drives one command; returns at the negedge of t+1. at_cnt >= 0 aligns acceptance to that counter value.
  task automatic send_cmd(input logic on, input logic [7:0] note, input logic [15:0] level, input int at_cnt);
    int n = 0;
    while (!(cmd_ready === 1'b1 && (at_cnt < 0 || tb_cnt == at_cnt)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout got ready=%b exp ready=1 within 50 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_on    = on;
    cmd_note  = note;
    cmd_level = level;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_on    = 1'b0;
    cmd_note  = 8'h00;
    cmd_level = 16'h0000;
  endtask

  task automatic step_tick();
    int n = 0;
    while (tb_cnt != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout got no tick exp tick within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_on    = 1'b0;
    cmd_note  = 8'h00;
    cmd_level = 16'h0000;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 8'h11;
    cmd_level = 16'h1000;
    repeat (2) @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    n_cmp++; if (pwm_regs !== 128'h0) begin n_bad++; $display("FAIL rst_pwm_regs got %h exp 0", pwm_regs); end
    cmd_valid = 1'b0;
    cmd_on    = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_resp_valid cycle %0d got %b exp 0", i, resp_valid); end
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready got %b exp 1", cmd_ready); end
    n_cmp++; if (ch_busy !== 8'h00) begin n_bad++; $display("FAIL idle_ch_busy got %h exp 00", ch_busy); end
    n_cmp++; if (pwm_regs !== 128'h0) begin n_bad++; $display("FAIL idle_pwm_regs got %h exp 0", pwm_regs); end
  endtask

  task automatic test_note_on();
    send_cmd(1'b1, 8'h3C, 16'hC000, 1);
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL on_resp_valid got %b exp 1", resp_valid); end
    n_cmp++; if (resp_ch !== 3'd0) begin n_bad++; $display("FAIL on_resp_ch got %0d exp 0", resp_ch); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL on_resp_err got %b exp 0", resp_err); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL on_ready_t1 got %b exp 0", cmd_ready); end
    n_cmp++; if (ch_busy !== 8'h01) begin n_bad++; $display("FAIL on_ch_busy got %h exp 01", ch_busy); end
    n_cmp++; if (lvl(0) !== 16'h0000) begin n_bad++; $display("FAIL on_level_t1 got %h exp 0000", lvl(0)); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL on_ready_t2 got %b exp 1", cmd_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL on_resp_pulse got %b exp 0", resp_valid); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h4000) begin n_bad++; $display("FAIL attack_1 got %h exp 4000", lvl(0)); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h8000) begin n_bad++; $display("FAIL attack_2 got %h exp 8000", lvl(0)); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'hC000) begin n_bad++; $display("FAIL attack_3 got %h exp C000", lvl(0)); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'hC000) begin n_bad++; $display("FAIL sustain got %h exp C000", lvl(0)); end
  endtask

  task automatic test_note_off();
    send_cmd(1'b0, 8'h3C, 16'h0000, -1);
    n_cmp++; if (resp_err !== 1'b0 || resp_ch !== 3'd0) begin n_bad++; $display("FAIL off_resp got err=%b ch=%0d exp err=0 ch=0", resp_err, resp_ch); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h8000) begin n_bad++; $display("FAIL release_1 got %h exp 8000", lvl(0)); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h4000 || ch_busy[0] !== 1'b1) begin n_bad++; $display("FAIL release_2 got lvl=%h busy=%b exp lvl=4000 busy=1", lvl(0), ch_busy[0]); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h0000 || ch_busy[0] !== 1'b0) begin n_bad++; $display("FAIL release_3 got lvl=%h busy=%b exp lvl=0000 busy=0", lvl(0), ch_busy[0]); end
  endtask

  task automatic test_full_alloc();
    logic [15:0]  lv_tab [8];
    logic [127:0] exp_regs;
    lv_tab = '{16'h1000, 16'h2000, 16'hC000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000};
    exp_regs = '0;
    for (int i = 0; i < 8; i++) begin
      send_cmd(1'b1, 8'h3E + 8'(i), lv_tab[i], -1);
      n_cmp++; if (resp_ch !== 3'(i) || resp_err !== 1'b0) begin n_bad++; $display("FAIL alloc_%0d got ch=%0d err=%b exp ch=%0d err=0", i, resp_ch, resp_err, i); end
      exp_regs[16*i +: 16] = lv_tab[i];
    end
    repeat (4) step_tick();
    n_cmp++; if (pwm_regs !== exp_regs) begin n_bad++; $display("FAIL alloc_levels got %h exp %h", pwm_regs, exp_regs); end
    send_cmd(1'b1, 8'h60, 16'hFFFF, -1);
    n_cmp++; if (resp_err !== 1'b1 || resp_ch !== 3'd0) begin n_bad++; $display("FAIL full_resp got err=%b ch=%0d exp err=1 ch=0", resp_err, resp_ch); end
    n_cmp++; if (pwm_regs !== exp_regs || ch_busy !== 8'hFF) begin n_bad++; $display("FAIL full_nochange got busy=%h regs=%h exp busy=FF regs=%h", ch_busy, pwm_regs, exp_regs); end
    send_cmd(1'b0, 8'h99, 16'h0000, -1);
    n_cmp++; if (resp_err !== 1'b1 || resp_ch !== 3'd0) begin n_bad++; $display("FAIL off_absent got err=%b ch=%0d exp err=1 ch=0", resp_err, resp_ch); end
  endtask

  task automatic test_retrigger();
    send_cmd(1'b1, 8'h40, 16'h2000, -1);
    n_cmp++; if (resp_ch !== 3'd2 || resp_err !== 1'b0) begin n_bad++; $display("FAIL retrig_resp got ch=%0d err=%b exp ch=2 err=0", resp_ch, resp_err); end
    n_cmp++; if (lvl(2) !== 16'hC000) begin n_bad++; $display("FAIL retrig_keep got %h exp C000", lvl(2)); end
    step_tick();
    n_cmp++; if (lvl(2) !== 16'h2000) begin n_bad++; $display("FAIL retrig_jump got %h exp 2000", lvl(2)); end
    step_tick();
    n_cmp++; if (lvl(2) !== 16'h2000 || lvl(3) !== 16'h4000) begin n_bad++; $display("FAIL retrig_hold got ch2=%h ch3=%h exp ch2=2000 ch3=4000", lvl(2), lvl(3)); end
  endtask

  task automatic test_tick_collision();
    do_reset();
    send_cmd(1'b1, 8'h20, 16'h4000, -1);
    send_cmd(1'b1, 8'h21, 16'hFFFF, -1);
    send_cmd(1'b0, 8'h20, 16'h0000, -1);
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h0000 || lvl(1) !== 16'h8000 || ch_busy !== 8'h02) begin n_bad++; $display("FAIL coll_setup got ch0=%h ch1=%h busy=%h exp ch0=0000 ch1=8000 busy=02", lvl(0), lvl(1), ch_busy); end
    send_cmd(1'b1, 8'h22, 16'h8000, 3);
    n_cmp++; if (resp_ch !== 3'd0 || resp_err !== 1'b0) begin n_bad++; $display("FAIL coll_resp got ch=%0d err=%b exp ch=0 err=0", resp_ch, resp_err); end
    n_cmp++; if (lvl(0) !== 16'h0000 || lvl(1) !== 16'hC000) begin n_bad++; $display("FAIL coll_skip got ch0=%h ch1=%h exp ch0=0000 ch1=C000", lvl(0), lvl(1)); end
    step_tick();
    n_cmp++; if (lvl(0) !== 16'h4000 || lvl(1) !== 16'hFFFF) begin n_bad++; $display("FAIL coll_step got ch0=%h ch1=%h exp ch0=4000 ch1=FFFF", lvl(0), lvl(1)); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm_regs !== 128'h0 || ch_busy !== 8'h00) begin n_bad++; $display("FAIL async_rst got busy=%h regs=%h exp busy=00 regs=0", ch_busy, pwm_regs); end
    n_cmp++; if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 || resp_ch !== 3'd0) begin n_bad++; $display("FAIL async_rst_hs got ready=%b valid=%b ch=%0d exp ready=1 valid=0 ch=0", cmd_ready, resp_valid, resp_ch); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_note_off();
    test_full_alloc();
    test_retrigger();
    test_tick_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
